dqbpijx_acc: RTL and testbench
==============================

# dqbpijx_acc

Backward-pass counterpart to the dq forward-pass units: for one input column j, consumes per-link dfdq vectors in descending link order (7 down to 1). Accumulates child-propagated force derivatives, emits the dtau/dq entry for each link, and rotates the accumulated vector into the parent frame for the next link. Sits after the forward-pass dqfpijx array in the fproc datapath, one instance per input column.

## Interface
- WIDTH, 32, signed fixed-point word width
- DECIMAL_BITS, 16, fractional bits of every data word
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- valid_in  in  1  link data presented this cycle
- ready_out  out  1  block can accept; high only in IDLE
- link_in  in  3  link index, legal 1..7
- sinq_val_in, cosq_val_in  in  WIDTH each  sin/cos of link joint angle
- dfdq_curr_vec_in_{AX,AY,AZ,LX,LY,LZ}  in  WIDTH each  forward-pass dfdq of this link
- valid_out  out  1  one-cycle pulse, outputs updated
- link_out  out  3  link index of current result
- dtaudq_val_out  out  WIDTH  dtau_i/dq_j
- dfdq_prop_vec_out_{AX,AY,AZ,LX,LY,LZ}  out  WIDTH each  accumulated vector rotated to parent frame

## Operation
- FSM states: IDLE, SUM, MUL, ROT. Transfer = valid_in & ready_out & link_in in 1..7; link_in 0 never accepted (ready stays high, no state change).
- IDLE: ready_out=1. On transfer latch sin/cos and link_in; go SUM.
- SUM: sum_k = dfdq_curr_k + carry_k for all six components; carry forced to zero when latched link==7. Register sum; go MUL.
- MUL: register eight products c·AX, s·AY, s·AX, c·AY and same for LX/LY (2·WIDTH bits each). Go ROT.
- ROT: rescale each product by arithmetic shift right DECIMAL_BITS, truncate to WIDTH (wrap); compute AX'=c·AX−s·AY, AY'=s·AX+c·AY, AZ'=AZ, LX'=c·LX−s·LY, LY'=s·LX+c·LY, LZ'=LZ. Load outputs, load carry with rotated vector, dtaudq_val_out=sum_AZ (revolute about z), link_out=link; valid_out=1; go IDLE.
- Adds/subtracts wrap at WIDTH bits.
- Out-of-order links (e.g., 5 after 7) not checked; carry is used as-is.

## Timing
- Reset (reset==0 at a clk edge): state IDLE, ready_out=1, valid_out=0, link_out=0, dtaudq_val_out=0, all dfdq_prop outputs 0, carry 0, sum/product regs 0. Reset mid-operation abandons in-flight link, no valid_out.
- Latency: transfer at edge N, valid_out high for cycle N+3 only.
- Throughput: one link per 4 cycles; ready_out low during SUM, MUL, ROT.
- Outputs hold last value until next ROT or reset.
- valid_in while ready_out=0 ignored; data need not be held.
- Transfer in the cycle valid_out is high is legal (state is IDLE).

## Configuration
- DQBPIJX_ACC_SAT_EN defined: each rescaled product and each ROT sum saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1] instead of wrapping; SUM adders also saturate.
- Undefined: all arithmetic wraps as above. Cycle timing identical either way.

## Test plan
- Reset: hold reset=0 two cycles mid-MUL -> all outputs 0, ready_out=1, no valid_out pulse.
- Link 7, sin=0, cos=0x00010000, dfdq_curr AZ=0x00030000 others 0 -> 3 cycles later valid_out, dtaudq=0x00030000, prop AZ=0x00030000, link_out=7.
- Link 7, sin=0x00010000, cos=0, AX=0x00010000 -> prop AX=0, AY=0x00010000; then link 6, q=0, dfdq_curr AY=0x00010000 -> prop AY=0x00020000 (carry accumulated).
- Link 7 result with nonzero carry, then new link 7 -> carry discarded, output equals rotated dfdq_curr only.
- valid_in held high continuously, links 7..1 -> accepts spaced exactly 4 cycles, seven valid_out pulses, link_out 7..1; link_in=0 never accepted.
- Overflow: cos=0x7FFF0000, LX=0x7FFF0000, sin=0 -> without macro LX' wraps to truncated value; with DQBPIJX_ACC_SAT_EN LX'=0x7FFFFFFF.

Source files
------------

// File: rtl/dqbpijx_acc.sv
// dqbpijx_acc -- backward-pass dfdq accumulator for one input column j.
//
// Consumes per-link forward-pass dfdq vectors in descending link order
// (7 down to 1). Each link adds the child-propagated carry to its own dfdq
// vector, emits dtau/dq (the angular-z component of that sum; the joint is
// revolute about z) and rotates the summed vector into the parent frame.
// The rotated vector becomes the carry for the next link.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-low reset
//   valid_in / ready_out     transfer handshake (ready only in IDLE)
//   link_in                  link index 1..7 (0 is never accepted)
//   sinq_val_in, cosq_val_in sin/cos of the link joint angle
//   dfdq_curr_vec_in_*       forward-pass dfdq of this link (AX..LZ)
//   valid_out                one-cycle pulse when outputs update
//   link_out                 link index of the current result
//   dtaudq_val_out           dtau_i/dq_j
//   dfdq_prop_vec_out_*      accumulated vector rotated to the parent frame
//
// Configuration macro: DQBPIJX_ACC_SAT_EN -- when defined, every add, subtract
// and product rescale saturates to the signed WIDTH range instead of wrapping.
// Cycle timing is identical either way.

module dqbpijx_acc #(
    parameter int WIDTH        = 32,
    parameter int DECIMAL_BITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [2:0]       link_in,
    input  logic [WIDTH-1:0] sinq_val_in,
    input  logic [WIDTH-1:0] cosq_val_in,
    input  logic [WIDTH-1:0] dfdq_curr_vec_in_AX,
    input  logic [WIDTH-1:0] dfdq_curr_vec_in_AY,
    input  logic [WIDTH-1:0] dfdq_curr_vec_in_AZ,
    input  logic [WIDTH-1:0] dfdq_curr_vec_in_LX,
    input  logic [WIDTH-1:0] dfdq_curr_vec_in_LY,
    input  logic [WIDTH-1:0] dfdq_curr_vec_in_LZ,
    output logic             valid_out,
    output logic [2:0]       link_out,
    output logic [WIDTH-1:0] dtaudq_val_out,
    output logic [WIDTH-1:0] dfdq_prop_vec_out_AX,
    output logic [WIDTH-1:0] dfdq_prop_vec_out_AY,
    output logic [WIDTH-1:0] dfdq_prop_vec_out_AZ,
    output logic [WIDTH-1:0] dfdq_prop_vec_out_LX,
    output logic [WIDTH-1:0] dfdq_prop_vec_out_LY,
    output logic [WIDTH-1:0] dfdq_prop_vec_out_LZ
);

    typedef enum logic [1:0] {IDLE, SUM, MUL, ROT} state_t;

    // Vector component order used by every 6-entry array: AX AY AZ LX LY LZ.
`ifdef DQBPIJX_ACC_SAT_EN
    localparam logic signed [WIDTH:0]     SUM_MAX  = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0]     SUM_MIN  = {2'b11, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] PROD_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] PROD_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] add_w(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sub);
        logic signed [WIDTH:0] v;
        v = sub ? ($signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b}))
                : ($signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b}));
        if (v > SUM_MAX) return SUM_MAX[WIDTH-1:0];
        if (v < SUM_MIN) return SUM_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] rescale(input logic signed [2*WIDTH-1:0] p);
        logic signed [2*WIDTH-1:0] r;
        r = p >>> DECIMAL_BITS;
        if (r > PROD_MAX) return PROD_MAX[WIDTH-1:0];
        if (r < PROD_MIN) return PROD_MIN[WIDTH-1:0];
        return r[WIDTH-1:0];
    endfunction
`else
    function automatic logic [WIDTH-1:0] add_w(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sub);
        return sub ? (a - b) : (a + b);
    endfunction

    function automatic logic [WIDTH-1:0] rescale(input logic signed [2*WIDTH-1:0] p);
        return WIDTH'(p >>> DECIMAL_BITS);
    endfunction
`endif

    state_t state_q, state_d;
    logic   accept;

    logic [WIDTH-1:0]          sin_q, cos_q;
    logic [2:0]                link_q;
    logic [WIDTH-1:0]          cur_d   [6];
    logic [WIDTH-1:0]          cur_q   [6];
    logic [WIDTH-1:0]          carry_q [6];
    logic [WIDTH-1:0]          sum_q   [6];
    logic [WIDTH-1:0]          rot_d   [6];
    logic [WIDTH-1:0]          prop_q  [6];
    logic signed [2*WIDTH-1:0] prod_q  [8];
    logic                      valid_q;
    logic [2:0]                link_out_q;
    logic [WIDTH-1:0]          dtau_q;

    assign ready_out = (state_q == IDLE);
    assign accept    = valid_in && ready_out && (link_in != 3'd0);

    assign cur_d[0] = dfdq_curr_vec_in_AX;
    assign cur_d[1] = dfdq_curr_vec_in_AY;
    assign cur_d[2] = dfdq_curr_vec_in_AZ;
    assign cur_d[3] = dfdq_curr_vec_in_LX;
    assign cur_d[4] = dfdq_curr_vec_in_LY;
    assign cur_d[5] = dfdq_curr_vec_in_LZ;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SUM;
            SUM:     state_d = MUL;
            MUL:     state_d = ROT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Products are indexed c*AX, s*AY, s*AX, c*AY, then the same for LX/LY.
    always_comb begin
        rot_d[0] = add_w(rescale(prod_q[0]), rescale(prod_q[1]), 1'b1);
        rot_d[1] = add_w(rescale(prod_q[2]), rescale(prod_q[3]), 1'b0);
        rot_d[2] = sum_q[2];
        rot_d[3] = add_w(rescale(prod_q[4]), rescale(prod_q[5]), 1'b1);
        rot_d[4] = add_w(rescale(prod_q[6]), rescale(prod_q[7]), 1'b0);
        rot_d[5] = sum_q[5];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sin_q      <= '0;
            cos_q      <= '0;
            link_q     <= '0;
            valid_q    <= 1'b0;
            link_out_q <= '0;
            dtau_q     <= '0;
            for (int k = 0; k < 6; k++) begin
                cur_q[k]   <= '0;
                carry_q[k] <= '0;
                sum_q[k]   <= '0;
                prop_q[k]  <= '0;
            end
            for (int k = 0; k < 8; k++) prod_q[k] <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    sin_q  <= sinq_val_in;
                    cos_q  <= cosq_val_in;
                    link_q <= link_in;
                    // Data is captured here so the source need not hold it.
                    for (int k = 0; k < 6; k++) cur_q[k] <= cur_d[k];
                end
                SUM: begin
                    // Link 7 is the leaf of the chain: any leftover carry is stale.
                    for (int k = 0; k < 6; k++)
                        sum_q[k] <= add_w(cur_q[k], (link_q == 3'd7) ? '0 : carry_q[k], 1'b0);
                end
                MUL: begin
                    prod_q[0] <= $signed(cos_q) * $signed(sum_q[0]);
                    prod_q[1] <= $signed(sin_q) * $signed(sum_q[1]);
                    prod_q[2] <= $signed(sin_q) * $signed(sum_q[0]);
                    prod_q[3] <= $signed(cos_q) * $signed(sum_q[1]);
                    prod_q[4] <= $signed(cos_q) * $signed(sum_q[3]);
                    prod_q[5] <= $signed(sin_q) * $signed(sum_q[4]);
                    prod_q[6] <= $signed(sin_q) * $signed(sum_q[3]);
                    prod_q[7] <= $signed(cos_q) * $signed(sum_q[4]);
                end
                default: begin
                    for (int k = 0; k < 6; k++) begin
                        prop_q[k]  <= rot_d[k];
                        carry_q[k] <= rot_d[k];
                    end
                    dtau_q     <= sum_q[2];
                    link_out_q <= link_q;
                    valid_q    <= 1'b1;
                end
            endcase
        end
    end

    assign valid_out            = valid_q;
    assign link_out             = link_out_q;
    assign dtaudq_val_out       = dtau_q;
    assign dfdq_prop_vec_out_AX = prop_q[0];
    assign dfdq_prop_vec_out_AY = prop_q[1];
    assign dfdq_prop_vec_out_AZ = prop_q[2];
    assign dfdq_prop_vec_out_LX = prop_q[3];
    assign dfdq_prop_vec_out_LY = prop_q[4];
    assign dfdq_prop_vec_out_LZ = prop_q[5];

endmodule

// File: tb/tb_dqbpijx_acc.sv
module tb_dqbpijx_acc;
  logic        gclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out, valid_out;
  logic [2:0]  link_in = '0, link_out;
  logic [31:0] sinq = '0, cosq = '0, dtau;
  logic [31:0] cur [6];
  logic [31:0] prop [6];

  always #5 gclk = ~gclk;

  dqbpijx_acc #(.WIDTH(32), .DECIMAL_BITS(16)) dut (
    .clk(gclk), .reset(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .link_in(link_in), .sinq_val_in(sinq), .cosq_val_in(cosq),
    .dfdq_curr_vec_in_AX(cur[0]), .dfdq_curr_vec_in_AY(cur[1]), .dfdq_curr_vec_in_AZ(cur[2]),
    .dfdq_curr_vec_in_LX(cur[3]), .dfdq_curr_vec_in_LY(cur[4]), .dfdq_curr_vec_in_LZ(cur[5]),
    .valid_out(valid_out), .link_out(link_out), .dtaudq_val_out(dtau),
    .dfdq_prop_vec_out_AX(prop[0]), .dfdq_prop_vec_out_AY(prop[1]), .dfdq_prop_vec_out_AZ(prop[2]),
    .dfdq_prop_vec_out_LX(prop[3]), .dfdq_prop_vec_out_LY(prop[4]), .dfdq_prop_vec_out_LZ(prop[5]));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (Q16 fixed-point arithmetic) ----------------
  function automatic int fit(input longint v);
`ifdef DQBPIJX_ACC_SAT_EN
    if (v > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (v < -64'sd2147483648) return 32'h80000000;
`endif
    return int'(v);
  endfunction

  function automatic int fmul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return fit(p >>> 16);
  endfunction

  typedef struct { int link; int dtau; int p[6]; int cyc; } exp_t;

  exp_t   q[$];
  exp_t   last;
  int     carry_m [6];
  int     cyc = 0;
  int     acc_cnt = 0;
  int     acc_log[$];

  always @(posedge gclk) cyc++;

  always @(negedge gclk) begin
    exp_t e;
    int   sm [6];
    int   s, c;
    if (!rst_n) begin
      q.delete();
      for (int k = 0; k < 6; k++) carry_m[k] = 0;
      last.link = 0; last.dtau = 0; last.cyc = 0;
      for (int k = 0; k < 6; k++) last.p[k] = 0;
    end else begin
      if (valid_out) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("latency", cyc - e.cyc, 4);
          last = e;
        end
      end else if (q.size() != 0 && cyc - q[0].cyc >= 4) begin
        chk("missing_valid", 0, 1);
        last = q.pop_front();
      end
      chk("ready", {31'b0, ready_out}, {31'b0, q.size() == 0});
      chk("link_out", {29'b0, link_out}, last.link);
      chk("dtau", dtau, last.dtau);
      for (int k = 0; k < 6; k++) chk($sformatf("prop%0d", k), prop[k], last.p[k]);
      if (valid_in && ready_out && link_in != 0) begin
        s = $signed(sinq); c = $signed(cosq);
        for (int k = 0; k < 6; k++)
          sm[k] = fit(longint'($signed(cur[k])) + ((link_in == 7) ? 0 : carry_m[k]));
        e.link = link_in;
        e.cyc  = cyc;
        e.dtau = sm[2];
        e.p[0] = fit(longint'(fmul(c, sm[0])) - fmul(s, sm[1]));
        e.p[1] = fit(longint'(fmul(s, sm[0])) + fmul(c, sm[1]));
        e.p[2] = sm[2];
        e.p[3] = fit(longint'(fmul(c, sm[3])) - fmul(s, sm[4]));
        e.p[4] = fit(longint'(fmul(s, sm[3])) + fmul(c, sm[4]));
        e.p[5] = sm[5];
        for (int k = 0; k < 6; k++) carry_m[k] = e.p[k];
        q.push_back(e);
        acc_cnt++;
        acc_log.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  task automatic set_in(input int l, input int s, input int c, input logic [5:0][31:0] v);
    link_in = 3'(l); sinq = s; cosq = c;
    for (int k = 0; k < 6; k++) cur[k] = v[k];
  endtask

  // Present one link and hold it until the block takes it.
  task automatic send(input int l, input int s, input int c, input logic [5:0][31:0] v);
    int n;
    valid_in = 1'b1;
    set_in(l, s, c, v);
    n = 0;
    do begin @(negedge gclk); n++; end while (!ready_out && n < 40);
    if (n >= 40) chk("send_timeout", 0, 1);
    tick(1);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin @(negedge gclk); n++; end
    if (n >= 40) chk("drain_timeout", 0, 1);
    tick(1);
  endtask

  function automatic logic [5:0][31:0] vec1(input int idx, input int val);
    logic [5:0][31:0] v;
    v = '0;
    v[idx] = val;
    return v;
  endfunction

  function automatic int rq();
    return int'($urandom_range(0, 131072)) - 65536;
  endfunction

  function automatic logic [5:0][31:0] rvec();
    logic [5:0][31:0] v;
    for (int k = 0; k < 6; k++)
      v[k] = ($urandom_range(0, 7) == 0) ? $urandom : 32'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [5:0][31:0] v;
    for (int k = 0; k < 6; k++) cur[k] = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_ready", {31'b0, ready_out}, 1);
    chk("rst_valid", {31'b0, valid_out}, 0);
    chk("rst_dtau", dtau, 0);

    // Link 7, identity rotation, AZ only.
    send(7, 0, 32'h00010000, vec1(2, 32'h00030000));
    drain();
    chk("d1_dtau", dtau, 32'h00030000);
    chk("d1_propAZ", prop[2], 32'h00030000);
    chk("d1_link", {29'b0, link_out}, 7);

    // 90-degree rotation, then carry accumulation on link 6.
    send(7, 32'h00010000, 0, vec1(0, 32'h00010000));
    drain();
    chk("d2_propAX", prop[0], 0);
    chk("d2_propAY", prop[1], 32'h00010000);
    send(6, 0, 32'h00010000, vec1(1, 32'h00010000));
    drain();
    chk("d3_propAY", prop[1], 32'h00020000);

    // New link 7 discards the nonzero carry.
    send(7, 0, 32'h00010000, vec1(3, 5));
    drain();
    chk("d4_propAY", prop[1], 0);
    chk("d4_propLX", prop[3], 5);

    // Overflow on the LX product.
    send(7, 0, 32'h7FFF0000, vec1(3, 32'h7FFF0000));
    drain();
`ifdef DQBPIJX_ACC_SAT_EN
    chk("ovf_propLX", prop[3], 32'h7FFFFFFF);
`else
    chk("ovf_propLX", prop[3], 32'h00010000);
`endif

    // link_in = 0 is never accepted.
    n0 = acc_cnt;
    valid_in = 1'b1;
    set_in(0, rq(), rq(), rvec());
    tick(8);
    valid_in = 1'b0;
    chk("link0_accepts", acc_cnt - n0, 0);

    // valid_in held high through a full 7..1 chain.
    acc_log.delete();
    valid_in = 1'b1;
    for (int l = 7; l >= 1; l--) begin
      int n;
      set_in(l, rq(), rq(), rvec());
      n = 0;
      do begin @(negedge gclk); n++; end while (!ready_out && n < 40);
      if (n >= 40) chk("stream_timeout", 0, 1);
      tick(1);
    end
    valid_in = 1'b0;
    drain();
    chk("stream_count", acc_log.size(), 7);
    for (int i = 1; i < acc_log.size(); i++)
      chk("stream_spacing", acc_log[i] - acc_log[i-1], 4);

    // Reset during MUL: no pulse, outputs cleared, carry cleared.
    send(7, rq(), rq(), rvec());
    tick(1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rstmid_dtau", dtau, 0);
    chk("rstmid_propAX", prop[0], 0);
    chk("rstmid_ready", {31'b0, ready_out}, 1);
    send(5, 0, 32'h00010000, vec1(4, 32'h00000100));
    drain();
    chk("rstmid_carry", prop[4], 32'h00000100);

    // Randomized chains with junk valid_in while busy.
    for (int ch = 0; ch < 20; ch++) begin
      int top;
      top = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 7;
      for (int l = top; l >= 1; l--) begin
        v = rvec();
        send(l, ($urandom_range(0, 5) == 0) ? int'($urandom) : rq(), rq(), v);
        if ($urandom_range(0, 1) == 1) begin
          valid_in = 1'b1;
          set_in(int'($urandom_range(0, 7)), rq(), rq(), rvec());
          tick(2);
          valid_in = 1'b0;
        end
        tick($urandom_range(0, 2));
      end
    end
    drain();
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
